divisor_secuencial: RTL and testbench

Sequential signed integer divider: the inverse counterpart of the team's sequential multiplier, using the same `start`/`Fin` handshake. It computes the quotient and remainder of two `NUM_BITS` two's-complement operands with one restoring-division step per clock. The quotient truncates toward zero, matching Verilog `/` and `%`. It sits beside the multiplier in the arithmetic unit and is driven by the same control logic.

---
 rtl/divisor_secuencial_if.sv | 23 ++
 rtl/divisor_secuencial.sv | 104 ++++++++++
 tb/tb_divisor_secuencial.sv | 137 +++++++++++++
 3 files changed

// File: rtl/divisor_secuencial_if.sv
// Handshake and operand/result bundle shared by the sequential divider and its driver.
// The master drives the request and operands; the slave returns the registered results.
interface divisor_secuencial_if #(
    parameter int NUM_BITS = 4
);
    logic                       start;
    logic signed [NUM_BITS-1:0] dividendo;
    logic signed [NUM_BITS-1:0] divisor;
    logic signed [NUM_BITS-1:0] cociente;
    logic signed [NUM_BITS-1:0] resto;
    logic                       Fin;
    logic                       div_cero;

    modport master (
        output start, dividendo, divisor,
        input  cociente, resto, Fin, div_cero
    );

    modport slave (
        input  start, dividendo, divisor,
        output cociente, resto, Fin, div_cero
    );
endinterface

// File: rtl/divisor_secuencial.sv
// Sequential signed divider: one restoring step per clock on operand magnitudes,
// followed by a sign-fixup edge. The quotient truncates toward zero, like Verilog / and %.
module divisor_secuencial #(
    parameter int NUM_BITS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    divisor_secuencial_if.slave  bus
);
    localparam int CNT_W = $clog2(NUM_BITS + 1);

    typedef enum logic [1:0] {IDLE, ITERA, AJUSTE, FIN} state_t;

    state_t                      state, state_nx;
    logic                        accept;
    logic [CNT_W-1:0]            cnt;
    logic                        last_step;
    logic [NUM_BITS-1:0]         acc;
    logic [NUM_BITS-1:0]         mag_d;
    logic [NUM_BITS:0]           rem;
    logic signed [NUM_BITS-1:0]  dvd_raw;
    logic                        sign_q;
    logic                        sign_r;
    logic [NUM_BITS+1:0]         shl;
    logic [NUM_BITS+1:0]         diff;

    function automatic logic [NUM_BITS-1:0] neg_n(input logic [NUM_BITS-1:0] v);
        return ~v + NUM_BITS'(1);
    endfunction

    // The magnitude of the most negative value is 2^(N-1), which still fits in N unsigned bits.
    function automatic logic [NUM_BITS-1:0] mag_n(input logic signed [NUM_BITS-1:0] v);
        return v[NUM_BITS-1] ? neg_n(v) : v;
    endfunction

    assign last_step = (cnt == CNT_W'(NUM_BITS - 1));
    assign shl       = {rem, acc[NUM_BITS-1]};
    assign diff      = shl - {2'b00, mag_d};

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        case (state)
            IDLE, FIN: begin
                if (bus.start) begin
                    accept   = 1'b1;
                    state_nx = (bus.divisor == '0) ? AJUSTE : ITERA;
                end
            end
            ITERA:   if (last_step) state_nx = AJUSTE;
            AJUSTE:  state_nx = FIN;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            bus.cociente <= '0;
            bus.resto    <= '0;
            bus.Fin      <= 1'b0;
            bus.div_cero <= 1'b0;
        end else begin
            case (state)
                IDLE, FIN: begin
                    if (accept) begin
                        acc          <= mag_n(bus.dividendo);
                        mag_d        <= mag_n(bus.divisor);
                        dvd_raw      <= bus.dividendo;
                        sign_q       <= bus.dividendo[NUM_BITS-1] ^ bus.divisor[NUM_BITS-1];
                        sign_r       <= bus.dividendo[NUM_BITS-1];
                        rem          <= '0;
                        cnt          <= '0;
                        bus.Fin      <= 1'b0;
                        bus.div_cero <= 1'b0;
                    end
                end
                ITERA: begin
                    // diff's top bit is the borrow: clear means the trial subtraction fits.
                    rem <= diff[NUM_BITS+1] ? shl[NUM_BITS:0] : diff[NUM_BITS:0];
                    acc <= {acc[NUM_BITS-2:0], ~diff[NUM_BITS+1]};
                    cnt <= cnt + CNT_W'(1);
                end
                AJUSTE: begin
                    if (mag_d == '0) begin
                        bus.cociente <= '1;
                        bus.resto    <= dvd_raw;
                        bus.div_cero <= 1'b1;
                    end else begin
                        bus.cociente <= $signed(sign_q ? neg_n(acc) : acc);
                        bus.resto    <= $signed(sign_r ? neg_n(rem[NUM_BITS-1:0]) : rem[NUM_BITS-1:0]);
                    end
                    bus.Fin <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_divisor_secuencial.sv
// Directed and exhaustive checks of the 4-bit sequential divider against hand-computed
// results and the language's own signed / and % operators.
module tb_divisor_secuencial;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    divisor_secuencial_if #(.NUM_BITS(4)) bus ();

    divisor_secuencial #(.NUM_BITS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Called at a negative edge; returns at the negative edge where Fin is first seen high.
    task automatic do_div(input int a, input int b, input int eq, input int er,
                          input int edz, input int elat);
        int    cyc;
        string t;
        t = $sformatf("%0d/%0d", a, b);
        bus.dividendo = 4'(a);
        bus.divisor   = 4'(b);
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk({t, " fin_low"}, int'(bus.Fin), 0);
        cyc = 0;
        while (!bus.Fin && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk({t, " lat"}, cyc, elat);
        chk({t, " quo"}, int'($signed(bus.cociente)), eq);
        chk({t, " rem"}, int'($signed(bus.resto)), er);
        chk({t, " dz"},  int'(bus.div_cero), edz);
    endtask

    initial begin
        int cyc;
        logic signed [3:0] a4, b4, q4, r4;

        bus.start     = 1'b0;
        bus.dividendo = '0;
        bus.divisor   = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst quo", int'($signed(bus.cociente)), 0);
        chk("rst rem", int'($signed(bus.resto)), 0);
        chk("rst fin", int'(bus.Fin), 0);
        chk("rst dz",  int'(bus.div_cero), 0);

        do_div( 7,  2,  3,  1, 0, 5);
        repeat (3) @(negedge clk);
        chk("hold fin", int'(bus.Fin), 1);
        chk("hold quo", int'($signed(bus.cociente)), 3);
        do_div(-7,  2, -3, -1, 0, 5);
        do_div( 7, -2, -3,  1, 0, 5);
        do_div(-7, -2,  3, -1, 0, 5);
        do_div(-8, -1, -8,  0, 0, 5);
        do_div(-8,  1, -8,  0, 0, 5);
        do_div( 3,  5,  0,  3, 0, 5);
        do_div( 5,  0, -1,  5, 1, 1);
        do_div( 7,  2,  3,  1, 0, 5);

        // Reset two cycles into an operation abandons it.
        bus.dividendo = 4'(7);
        bus.divisor   = 4'(2);
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid rst quo", int'($signed(bus.cociente)), 0);
        chk("mid rst rem", int'($signed(bus.resto)), 0);
        chk("mid rst fin", int'(bus.Fin), 0);
        chk("mid rst dz",  int'(bus.div_cero), 0);
        repeat (6) @(negedge clk);
        chk("idle fin", int'(bus.Fin), 0);
        do_div( 6,  3,  2,  0, 0, 5);

        // A start pulse during ITERA and operand changes after acceptance are ignored.
        bus.dividendo = 4'(7);
        bus.divisor   = 4'(2);
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        cyc = 1;
        bus.dividendo = 4'(-3);
        bus.divisor   = 4'(1);
        bus.start     = 1'b1;
        @(negedge clk);
        cyc = 2;
        bus.start     = 1'b0;
        bus.dividendo = 4'(0);
        bus.divisor   = 4'(0);
        while (!bus.Fin && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("ign lat", cyc, 5);
        chk("ign quo", int'($signed(bus.cociente)), 3);
        chk("ign rem", int'($signed(bus.resto)), 1);
        chk("ign dz",  int'(bus.div_cero), 0);

        for (int a = -8; a < 8; a++) begin
            for (int b = -8; b < 8; b++) begin
                a4 = 4'(a);
                b4 = 4'(b);
                if (b == 0) begin
                    do_div(a, b, -1, a, 1, 1);
                end else begin
                    q4 = a4 / b4;
                    r4 = a4 % b4;
                    do_div(a, b, int'(q4), int'(r4), 0, 5);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
